// File: rtl/vocab_writer.sv
// Packs incoming words into a null-separated vocab SRAM image, one byte per cycle.
// Optional SCRUB/clear support is enabled by defining VOCAB_WRITER_CLEAR_EN.
module vocab_writer #(
  parameter int unsigned ADDR_WIDTH  = 4,
  parameter int unsigned WORD_LENGTH = 3,
  parameter int unsigned DATA_WIDTH  = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [WORD_LENGTH*DATA_WIDTH-1:0] in_word,
`ifdef VOCAB_WRITER_CLEAR_EN
  input  logic                              clear,
`endif
  output logic                              mem_we,
  output logic [ADDR_WIDTH-1:0]             mem_addr,
  output logic [DATA_WIDTH-1:0]             mem_din,
  output logic [ADDR_WIDTH:0]               wr_ptr,
  output logic [ADDR_WIDTH:0]               entry_count,
  output logic                              full,
  output logic                              err_overflow
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned IdxW  = $clog2(WORD_LENGTH + 1);
  localparam logic [ADDR_WIDTH+1:0] DepthSum = (ADDR_WIDTH + 2)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   FullThr  = (ADDR_WIDTH + 1)'(DEPTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
`ifdef VOCAB_WRITER_CLEAR_EN
    StTerm,
    StScrub
`else
    StTerm
`endif
  } state_e;

  state_e                            state_q, state_d;
  logic [ADDR_WIDTH:0]               wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]               count_q, count_d;
  logic                              err_q, err_d;
  logic [WORD_LENGTH*DATA_WIDTH-1:0] word_q, word_d;
  logic [IdxW-1:0]                   len_q, len_d;
  logic [IdxW-1:0]                   idx_q, idx_d;
  logic [IdxW-1:0]                   len_c;
  logic                              zero_seen;
  logic                              no_room;
`ifdef VOCAB_WRITER_CLEAR_EN
  logic [ADDR_WIDTH-1:0]             scrub_q, scrub_d;
`endif

  // Word length: leading nonzero bytes, stopping at the first zero byte.
  always_comb begin
    len_c     = '0;
    zero_seen = 1'b0;
    for (int k = 0; k < int'(WORD_LENGTH); k++) begin
      if (!zero_seen && (in_word[k*DATA_WIDTH +: DATA_WIDTH] != '0)) begin
        len_c = len_c + 1'b1;
      end else begin
        zero_seen = 1'b1;
      end
    end
  end

  assign no_room = ({1'b0, wr_ptr_q} + (ADDR_WIDTH + 2)'(len_c) + (ADDR_WIDTH + 2)'(1)) > DepthSum;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    err_d    = err_q;
    word_d   = word_q;
    len_d    = len_q;
    idx_d    = idx_q;
`ifdef VOCAB_WRITER_CLEAR_EN
    scrub_d  = scrub_q;
`endif
    in_ready = 1'b0;
    mem_we   = 1'b0;
    mem_addr = wr_ptr_q[ADDR_WIDTH-1:0];
    mem_din  = '0;
    case (state_q)
      StIdle: begin
        in_ready = 1'b1;
`ifdef VOCAB_WRITER_CLEAR_EN
        if (clear) begin
          scrub_d = '0;
          state_d = StScrub;
        end else if (in_valid) begin
`else
        if (in_valid) begin
`endif
          if (len_c == '0) begin
            state_d = StIdle;
          end else if (no_room) begin
            err_d = 1'b1;
          end else begin
            word_d  = in_word;
            len_d   = len_c;
            idx_d   = '0;
            state_d = StWrite;
          end
        end
      end
      StWrite: begin
        mem_we   = 1'b1;
        mem_din  = word_q[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH];
        wr_ptr_d = wr_ptr_q + 1'b1;
        idx_d    = idx_q + 1'b1;
        if (idx_q == len_q - 1'b1) state_d = StTerm;
      end
      StTerm: begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
        count_d  = count_q + 1'b1;
        state_d  = StIdle;
      end
`ifdef VOCAB_WRITER_CLEAR_EN
      StScrub: begin
        mem_we   = 1'b1;
        mem_addr = scrub_q;
        scrub_d  = scrub_q + 1'b1;
        if (scrub_q == '1) begin
          wr_ptr_d = '0;
          count_d  = '0;
          err_d    = 1'b0;
          state_d  = StIdle;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
      word_q   <= '0;
      len_q    <= '0;
      idx_q    <= '0;
`ifdef VOCAB_WRITER_CLEAR_EN
      scrub_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
      word_q   <= word_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
`ifdef VOCAB_WRITER_CLEAR_EN
      scrub_q  <= scrub_d;
`endif
    end
  end

  assign wr_ptr       = wr_ptr_q;
  assign entry_count  = count_q;
  assign err_overflow = err_q;
  assign full         = wr_ptr_q >= FullThr;

endmodule

// File: doc/vocab_writer.md
VOCAB_WRITER -- requirements
Module: vocab_writer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, which sets the vocab SRAM address width; DEPTH = 2**ADDR_WIDTH.
REQ-002 SHALL have parameter WORD_LENGTH, default 3, the maximum bytes per input word.
REQ-003 SHALL have parameter DATA_WIDTH, default 8, the bits per byte/SRAM location.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  in_word is presented.
REQ-007 SHALL have port in_ready  output  1  block can accept a word this cycle.
REQ-008 SHALL have port in_word  input  WORD_LENGTH*DATA_WIDTH  packed word; byte k = bits [(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH]; byte 0 is the first character.
REQ-009 SHALL have port mem_we  output  1  SRAM write strobe.
REQ-010 SHALL have port mem_addr  output  ADDR_WIDTH  SRAM write address.
REQ-011 SHALL have port mem_din  output  DATA_WIDTH  SRAM write data.
REQ-012 SHALL have port wr_ptr  output  ADDR_WIDTH+1  next free address, range 0..DEPTH.
REQ-013 SHALL have port entry_count  output  ADDR_WIDTH+1  number of words stored.
REQ-014 SHALL have port full  output  1  asserted when wr_ptr >= DEPTH-1 (no room for a 1-byte word plus terminator).
REQ-015 SHALL have port err_overflow  output  1  sticky flag: a word was dropped for lack of space.

Function
REQ-016 SHALL write each word as its leading nonzero bytes followed by one 0x00 terminator at consecutive addresses, producing the null-separated vocab layout read by the matcher.
REQ-017 SHALL define word length L as the count of bytes before the first zero byte, capped at WORD_LENGTH.
REQ-018 SHALL implement states IDLE, WRITE and TERM (plus SCRUB under REQ-032).
REQ-019 In IDLE, in_ready SHALL be 1; a word is accepted on in_valid && in_ready.
REQ-020 On accept with L==0, the word SHALL be discarded: no writes, no counter change, remain in IDLE.
REQ-021 On accept with wr_ptr+L+1 > DEPTH, the word SHALL be discarded and err_overflow set, remaining in IDLE.
REQ-022 Otherwise, the block SHALL latch in_word and L and go to WRITE with byte index 0.
REQ-023 In WRITE, the block SHALL drive mem_we=1, mem_addr=wr_ptr and mem_din=byte[idx], then increment wr_ptr and idx; it SHALL move to TERM after byte L-1.
REQ-024 In TERM, the block SHALL drive mem_we=1 and mem_din=0, increment wr_ptr and entry_count, and return to IDLE.
REQ-025 in_ready SHALL be 0 outside IDLE; a word of length L SHALL take L+1 write cycles, the first in the cycle after acceptance.
REQ-026 mem_we SHALL be 0 in IDLE; mem_addr/mem_din are don't-care when mem_we=0.
REQ-027 in_word SHALL be ignored after acceptance, since the latched copy is used.
REQ-028 A word that ends exactly at DEPTH SHALL be accepted (wr_ptr becomes DEPTH); the address SHALL never wrap.

Reset
REQ-029 rst SHALL take priority over all inputs in any state, including mid-word.
REQ-030 After reset: state=IDLE, wr_ptr=0, entry_count=0, err_overflow=0, mem_we=0, in_ready=1, full=0.
REQ-031 A word interrupted by reset SHALL leave partial bytes in SRAM and SHALL NOT be counted.

Configuration
REQ-032 With VOCAB_WRITER_CLEAR_EN defined: input port clear (1 bit) SHALL exist; clear in IDLE (priority over in_valid) SHALL enter SCRUB, writing 0x00 to addresses 0..DEPTH-1 over DEPTH cycles (in_ready=0), then set wr_ptr=0, entry_count=0, err_overflow=0 and return to IDLE; clear outside IDLE SHALL be ignored.
REQ-033 Without VOCAB_WRITER_CLEAR_EN: no clear port and no SCRUB state; only rst empties the vocab.

Verification
REQ-034 Defaults; after reset send in_word=24'h636261 ("abc") -> writes addr0..3 = 61,62,63,00 on four consecutive cycles; wr_ptr=4, entry_count=1.
REQ-035 Then in_word=24'h006261 ("ab") -> writes addr4..6 = 61,62,00; wr_ptr=7, entry_count=2; in_ready low for 3 cycles.
REQ-036 in_word=24'h000000, then in_word=24'h630000 -> no mem_we, counters unchanged (L=0 in both).
REQ-037 Four "abc" words -> wr_ptr=16, full=1; then "a" (24'h000061) -> no write, err_overflow=1, entry_count=4.
REQ-038 rst asserted in the second WRITE cycle of "abc" -> next cycle IDLE, wr_ptr=0, entry_count=0, mem_we=0.
REQ-039 With VOCAB_WRITER_CLEAR_EN: after two words, pulse clear -> 16 zero writes to addr0..15, then wr_ptr=0, in_ready=1.
